// File: rtl/proc_pkg.sv
// Shared processor definitions: program-counter width, decoded opcodes and the
// interrupt-sequencer FSM state encoding.
package proc_pkg;

  localparam int PC_ADDR_W = 16;

  localparam logic [5:0] OPC_NOP  = 6'b000000;
  localparam logic [5:0] OPC_LOAD = 6'b000001;
  localparam logic [5:0] OPC_JMP  = 6'b010000;
  localparam logic [5:0] OPC_CALL = 6'b010001;
  localparam logic [5:0] OPC_RET  = 6'b010010;
  localparam logic [5:0] OPC_RETI = 6'b011110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Index width that stays legal for a single-source configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest set bit of the eligible vector wins and is
// reported both as a binary index and as a one-hot grant.
module irq_priority_encoder
  import proc_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N_SRC-1:0] grant
);

  // Scanning from the top down lets the lowest index overwrite, giving it priority.
  always_comb begin
    valid = 1'b0;
    index = '0;
    grant = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid    = 1'b1;
        index    = i[IDX_W-1:0];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: pending/mask registers, fixed-priority grant FSM, service vector
// and return address. Define NESTED_IRQ_EN for preemption with a return stack.
module interrupt_sequencer
  import proc_pkg::*;
#(
  parameter int                N_SRC         = 4,
  parameter int                ADDR_W        = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] VECTOR_BASE   = 16'h0040,
  parameter logic [ADDR_W-1:0] VECTOR_STRIDE = 16'h0004,
  parameter logic [5:0]        OP_RETI       = OPC_RETI,
  parameter int                NEST_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_req,
  input  logic              mask_wr,
  input  logic [N_SRC-1:0]  mask_data,
  input  logic [5:0]        op_dec,
  input  logic [ADDR_W-1:0] current_address,
  output logic              interrupt,
  output logic [ADDR_W-1:0] vector_addr,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [N_SRC-1:0]  irq_ack,
  output logic              busy
);

  localparam int IDX_W = idx_width(N_SRC);

  irq_state_t        state;
  logic [N_SRC-1:0]  irq_prev;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  eligible;
  logic              enc_valid;
  logic [IDX_W-1:0]  enc_idx;
  logic [N_SRC-1:0]  enc_grant;
  logic [ADDR_W-1:0] vec_calc;

  assign eligible = pending & mask;
  assign vec_calc = VECTOR_BASE + (ADDR_W'(enc_idx) * VECTOR_STRIDE);

  irq_priority_encoder #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .eligible (eligible),
    .valid    (enc_valid),
    .index    (enc_idx),
    .grant    (enc_grant)
  );

  // A new edge in the acknowledge cycle must survive, so the set term is ORed last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '1;
    end else begin
      irq_prev <= irq_req;
      pending  <= (pending & ~irq_ack) | (irq_req & ~irq_prev);
      if (mask_wr) begin
        mask <= mask_data;
      end
    end
  end

`ifdef NESTED_IRQ_EN
  localparam int SP_W = $clog2(NEST_DEPTH + 1);

  logic [ADDR_W-1:0] ret_stack [NEST_DEPTH];
  logic [IDX_W-1:0]  lvl_stack [NEST_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_top;
  logic              stack_full;
  logic [IDX_W-1:0]  level;
  logic [IDX_W-1:0]  grant_idx;

  assign sp_top     = sp - SP_W'(1);
  assign stack_full = (sp == SP_W'(NEST_DEPTH));

  // RETI is honoured before a preemption request that arrives in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      interrupt   <= 1'b0;
      vector_addr <= '0;
      ret_addr    <= '0;
      irq_ack     <= '0;
      busy        <= 1'b0;
      level       <= '0;
      grant_idx   <= '0;
      sp          <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        ret_stack[i] <= '0;
        lvl_stack[i] <= '0;
      end
    end else begin
      interrupt <= 1'b0;
      irq_ack   <= '0;
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            state       <= ST_GRANT;
            interrupt   <= 1'b1;
            irq_ack     <= enc_grant;
            vector_addr <= vec_calc;
            grant_idx   <= enc_idx;
            busy        <= 1'b1;
          end
        end
        ST_GRANT: begin
          ret_addr <= current_address;
          level    <= grant_idx;
          state    <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (op_dec == OP_RETI) begin
            if (sp != '0) begin
              sp       <= sp_top;
              ret_addr <= ret_stack[sp_top];
              level    <= lvl_stack[sp_top];
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (enc_valid && (enc_idx < level) && !stack_full) begin
            ret_stack[sp] <= ret_addr;
            lvl_stack[sp] <= level;
            sp            <= sp + SP_W'(1);
            state         <= ST_GRANT;
            interrupt     <= 1'b1;
            irq_ack       <= enc_grant;
            vector_addr   <= vec_calc;
            grant_idx     <= enc_idx;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  // Without nesting a service runs to its RETI; new requests simply wait as pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      interrupt   <= 1'b0;
      vector_addr <= '0;
      ret_addr    <= '0;
      irq_ack     <= '0;
      busy        <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      irq_ack   <= '0;
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            state       <= ST_GRANT;
            interrupt   <= 1'b1;
            irq_ack     <= enc_grant;
            vector_addr <= vec_calc;
            busy        <= 1'b1;
          end
        end
        ST_GRANT: begin
          ret_addr <= current_address;
          state    <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (op_dec == OP_RETI) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed testbench for interrupt_sequencer; expectations are hand-computed for the
// default parameters, with NESTED_IRQ_EN selecting the preemption expectations.
module tb_interrupt_sequencer;
  import proc_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_req;
  logic        mask_wr;
  logic [3:0]  mask_data;
  logic [5:0]  op_dec;
  logic [15:0] current_address;
  logic        interrupt;
  logic [15:0] vector_addr;
  logic [15:0] ret_addr;
  logic [3:0]  irq_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  interrupt_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .irq_req         (irq_req),
    .mask_wr         (mask_wr),
    .mask_data       (mask_data),
    .op_dec          (op_dec),
    .current_address (current_address),
    .interrupt       (interrupt),
    .vector_addr     (vector_addr),
    .ret_addr        (ret_addr),
    .irq_ack         (irq_ack),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] req, input logic [15:0] addr, input logic [5:0] op);
    irq_req         = req;
    current_address = addr;
    op_dec          = op;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b0;
    mask_wr   = 1'b0;
    mask_data = 4'b0000;
    apply_stimulus(4'b0000, 16'h0000, OPC_NOP);
    step();
    step();

    // Reset values
    check_output("rst_interrupt", interrupt, 0);
    check_output("rst_vector", vector_addr, 16'h0000);
    check_output("rst_ret", ret_addr, 16'h0000);
    check_output("rst_ack", irq_ack, 4'b0000);
    check_output("rst_busy", busy, 0);
    reset = 1'b1;
    step();
    check_output("idle_no_irq", interrupt, 0);

    // Single request from source 2, two-cycle latency
    $display("[TB] single request on source 2");
    apply_stimulus(4'b0100, 16'h0010, OPC_NOP);
    step();
    check_output("t2_latency1", interrupt, 0);
    step();
    check_output("t2_interrupt", interrupt, 1);
    check_output("t2_ack", irq_ack, 4'b0100);
    check_output("t2_vector", vector_addr, 16'h0048);
    check_output("t2_ret_before", ret_addr, 16'h0000);
    step();
    check_output("t2_int_pulse", interrupt, 0);
    check_output("t2_ack_pulse", irq_ack, 4'b0000);
    check_output("t2_ret", ret_addr, 16'h0010);
    check_output("t2_busy", busy, 1);
    apply_stimulus(4'b0000, 16'h0100, OPC_NOP);
    step();
    check_output("t2_busy_hold", busy, 1);
    apply_stimulus(4'b0000, 16'h0100, OPC_RETI);
    step();
    check_output("t2_reti_busy", busy, 0);
    apply_stimulus(4'b0000, 16'h0100, OPC_NOP);
    step();
    check_output("t2_idle_after", interrupt, 0);

    // Two simultaneous requests: priority then the mandatory idle gap
    $display("[TB] simultaneous requests on sources 1 and 3");
    apply_stimulus(4'b1010, 16'h0200, OPC_NOP);
    step();
    step();
    check_output("t3_ack1", irq_ack, 4'b0010);
    check_output("t3_vec1", vector_addr, 16'h0044);
    step();
    apply_stimulus(4'b1010, 16'h0200, OPC_RETI);
    step();
    check_output("t3_gap_int", interrupt, 0);
    check_output("t3_gap_busy", busy, 0);
    apply_stimulus(4'b1010, 16'h0200, OPC_NOP);
    step();
    check_output("t3_int3", interrupt, 1);
    check_output("t3_ack3", irq_ack, 4'b1000);
    check_output("t3_vec3", vector_addr, 16'h004C);
    step();
    apply_stimulus(4'b0000, 16'h0200, OPC_RETI);
    step();
    apply_stimulus(4'b0000, 16'h0200, OPC_NOP);
    step();

    // Mask off source 0, then unmask it
    $display("[TB] mask and unmask source 0");
    mask_data = 4'b1110;
    mask_wr   = 1'b1;
    step();
    mask_wr = 1'b0;
    apply_stimulus(4'b0001, 16'h0300, OPC_NOP);
    step();
    step();
    check_output("t4_masked_int", interrupt, 0);
    step();
    check_output("t4_masked_busy", busy, 0);
    mask_data = 4'b1111;
    mask_wr   = 1'b1;
    step();
    mask_wr = 1'b0;
    check_output("t4_old_mask", interrupt, 0);
    step();
    check_output("t4_unmask_int", interrupt, 1);
    check_output("t4_unmask_ack", irq_ack, 4'b0001);
    check_output("t4_unmask_vec", vector_addr, 16'h0040);
    step();
    apply_stimulus(4'b0000, 16'h0300, OPC_RETI);
    step();
    apply_stimulus(4'b0000, 16'h0300, OPC_NOP);
    step();

    // Higher-priority request during service of source 2
    $display("[TB] source 0 arrives while source 2 is in service");
    apply_stimulus(4'b0100, 16'h0020, OPC_NOP);
    step();
    step();
    check_output("t5_vec2", vector_addr, 16'h0048);
    step();
    check_output("t5_ret2", ret_addr, 16'h0020);
    apply_stimulus(4'b0101, 16'h0030, OPC_NOP);
    step();
    check_output("t5_pend_int", interrupt, 0);
    step();
`ifdef NESTED_IRQ_EN
    check_output("t5_preempt_int", interrupt, 1);
    check_output("t5_preempt_ack", irq_ack, 4'b0001);
    check_output("t5_preempt_vec", vector_addr, 16'h0040);
    step();
    check_output("t5_inner_ret", ret_addr, 16'h0030);
    check_output("t5_inner_busy", busy, 1);
    apply_stimulus(4'b0000, 16'h0030, OPC_RETI);
    step();
    check_output("t5_pop_ret", ret_addr, 16'h0020);
    check_output("t5_pop_busy", busy, 1);
    check_output("t5_pop_int", interrupt, 0);
    step();
    check_output("t5_final_busy", busy, 0);
`else
    check_output("t5_no_preempt", interrupt, 0);
    check_output("t5_still_busy", busy, 1);
    step();
    check_output("t5_no_preempt2", interrupt, 0);
    apply_stimulus(4'b0000, 16'h0030, OPC_RETI);
    step();
    check_output("t5_reti_busy", busy, 0);
    apply_stimulus(4'b0000, 16'h0030, OPC_NOP);
    step();
    check_output("t5_late_int", interrupt, 1);
    check_output("t5_late_vec", vector_addr, 16'h0040);
    step();
    check_output("t5_late_ret", ret_addr, 16'h0030);
    apply_stimulus(4'b0000, 16'h0030, OPC_RETI);
    step();
    check_output("t5_final_busy", busy, 0);
`endif
    apply_stimulus(4'b0000, 16'h0030, OPC_NOP);
    step();

    // New edge on source 1 in its own acknowledge cycle
    $display("[TB] re-request coinciding with acknowledge");
    apply_stimulus(4'b0010, 16'h0400, OPC_NOP);
    step();
    apply_stimulus(4'b0000, 16'h0400, OPC_NOP);
    step();
    check_output("t6_ack1", irq_ack, 4'b0010);
    apply_stimulus(4'b0010, 16'h0400, OPC_NOP);
    step();
    apply_stimulus(4'b0010, 16'h0400, OPC_RETI);
    step();
    check_output("t6_gap_int", interrupt, 0);
    apply_stimulus(4'b0010, 16'h0400, OPC_NOP);
    step();
    check_output("t6_regrant_int", interrupt, 1);
    check_output("t6_regrant_ack", irq_ack, 4'b0010);
    step();
    apply_stimulus(4'b0000, 16'h0400, OPC_RETI);
    step();
    apply_stimulus(4'b0000, 16'h0400, OPC_NOP);
    step();
    check_output("t6_done_busy", busy, 0);

    // Reset in the middle of a service with a masked request pending
    $display("[TB] reset during service");
    apply_stimulus(4'b0010, 16'h0500, OPC_NOP);
    step();
    step();
    check_output("t1_ack", irq_ack, 4'b0010);
    step();
    check_output("t1_busy", busy, 1);
    mask_data = 4'b0000;
    mask_wr   = 1'b1;
    apply_stimulus(4'b1010, 16'h0500, OPC_NOP);
    step();
    mask_wr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_output("t1_rst_busy", busy, 0);
    check_output("t1_rst_int", interrupt, 0);
    check_output("t1_rst_ret", ret_addr, 16'h0000);
    apply_stimulus(4'b0000, 16'h0500, OPC_NOP);
    step();
    reset = 1'b1;
    step();
    step();
    check_output("t1_no_pending", interrupt, 0);
    check_output("t1_idle_busy", busy, 0);
    apply_stimulus(4'b1000, 16'h0600, OPC_NOP);
    step();
    step();
    check_output("t1_mask_all1_int", interrupt, 1);
    check_output("t1_mask_all1_ack", irq_ack, 4'b1000);
    check_output("t1_mask_all1_vec", vector_addr, 16'h004C);
    step();
    apply_stimulus(4'b0000, 16'h0600, OPC_RETI);
    step();
    apply_stimulus(4'b0000, 16'h0600, OPC_NOP);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
